// File: rtl/router_input_buffer.sv
// Two-VC input buffer for one router port: per-VC flit FIFOs feeding a single
// registered output slot, with packet locking and round-robin between VCs.
module router_input_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 35
) (
  input  logic          clk,
  input  logic          RST_,
  input  logic [DW-1:0] IDATA,
  input  logic          IVALID,
  input  logic          IVCH,
  output logic [1:0]    ORDY,
  output logic [DW-1:0] ODATA,
  output logic          OVALID,
  output logic          OVCH,
  input  logic [1:0]    IACK,
  input  logic [1:0]    ILCK,
  output logic          OVF
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    nonempty;
  logic [1:0]    elig;
  logic [DW-1:0] head_data [2];

  logic          lock_act_reg;
  logic          lock_vc_reg;
  logic          last_vc_reg;
  logic          slot_free;
  logic          load;
  logic          sel;
  logic [DW-1:0] sel_data;
  logic [1:0]    sel_type;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_vc
      logic [DW-1:0] mem [DEPTH];
      logic [AW-1:0] wr_ptr_reg;
      logic [AW-1:0] rd_ptr_reg;
      logic [CW-1:0] count_reg;

      assign ORDY[gi]      = (count_reg != CW'(DEPTH));
      assign nonempty[gi]  = (count_reg != '0);
      assign push[gi]      = IVALID && (IVCH == 1'(gi)) && ORDY[gi];
      assign pop[gi]       = load && (sel == 1'(gi));
      assign head_data[gi] = mem[rd_ptr_reg];

      always_ff @(posedge clk) begin
        if (push[gi]) mem[wr_ptr_reg] <= IDATA;
      end

      // Pointers wrap naturally because DEPTH is a power of two.
      always_ff @(posedge clk or posedge RST_) begin
        if (RST_) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          count_reg <= count_reg + CW'(push[gi]) - CW'(pop[gi]);
        end
      end
    end
  endgenerate

  always_comb begin
    elig      = 2'b00;
    sel       = 1'b0;
    slot_free = 1'b0;
    load      = 1'b0;
    sel_data  = '0;
    sel_type  = 2'b00;
    // A packet in flight owns the slot; ILCK only gates the start of packets.
    if (lock_act_reg) elig = nonempty & (lock_vc_reg ? 2'b10 : 2'b01);
    else              elig = nonempty & ~ILCK;
    if (&elig) sel = ~last_vc_reg;
    else       sel = elig[1];
    slot_free = !OVALID || IACK[OVCH];
    load      = slot_free && (|elig);
    sel_data  = head_data[sel];
    sel_type  = sel_data[DW-1:DW-2];
  end

  always_ff @(posedge clk or posedge RST_) begin
    if (RST_) begin
      ODATA        <= '0;
      OVALID       <= 1'b0;
      OVCH         <= 1'b0;
      OVF          <= 1'b0;
      lock_act_reg <= 1'b0;
      lock_vc_reg  <= 1'b0;
      last_vc_reg  <= 1'b1;
    end else begin
      if (IVALID && !ORDY[IVCH]) OVF <= 1'b1;
      if (load) begin
        ODATA       <= sel_data;
        OVALID      <= 1'b1;
        OVCH        <= sel;
        last_vc_reg <= sel;
        // Stray body/tail on an unlocked VC passes through as a single flit.
        if (sel_type == T_HEAD) begin
          lock_act_reg <= 1'b1;
          lock_vc_reg  <= sel;
        end else if (sel_type == T_TAIL || sel_type == T_SINGLE) begin
          lock_act_reg <= 1'b0;
        end
      end else if (slot_free) begin
        OVALID <= 1'b0;
      end
    end
  end

endmodule
